// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage of the ez8 core.
//
// Generates program-ROM read addresses and keeps a hardware call/return stack.
// Each fetched word, its PC and a valid flag go to decode. Jump, call and ret
// from decode, and skip from skip_calc, can redirect or squash the fetch stream.
//
// Ports:
//   clk, reset_n      core clock; synchronous active-low reset
//   pause             stall: every register holds
//   skip              squash the instruction after the current one
//   jump/call/ret     redirect controls (priority ret > call > jump > skip)
//   target            jump/call destination
//   instr_addr        ROM read address (ROM has 1-cycle read latency)
//   instr_data        ROM read data
//   instr, pc         current instruction and its address
//   instr_valid       instr/pc hold a real instruction to execute
//   stack_overflow    sticky: call attempted with the stack full
//   stack_underflow   sticky: ret attempted with the stack empty
module fetch_unit #(
  parameter int PC_WIDTH    = 12,
  parameter int STACK_DEPTH = 8,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pause,
  input  logic                   skip,
  input  logic                   jump,
  input  logic                   call,
  input  logic                   ret,
  input  logic [PC_WIDTH-1:0]    target,
  output logic [PC_WIDTH-1:0]    instr_addr,
  input  logic [INSTR_WIDTH-1:0] instr_data,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   instr_valid,
  output logic                   stack_overflow,
  output logic                   stack_underflow
);

  // The pointer has one extra bit so "full" (== STACK_DEPTH) is representable.
  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = SP_W - 1;

  logic [PC_WIDTH-1:0] stack [STACK_DEPTH];
  logic [SP_W-1:0]     sp;

  logic             accept;
  logic             do_ret, do_call, do_jump, do_skip;
  logic             stack_empty, stack_full;
  logic [IDX_W-1:0] push_idx, pop_idx;

  // ROM data is the instruction; the PC alignment is done by the pc register.
  assign instr = instr_data;

  // NOTE: every signal gets a value on every path through always_comb, so no
  // latch can be inferred.
  always_comb begin
    accept      = instr_valid && !pause;
    do_ret      = accept && ret;
    do_call     = accept && !ret && call;
    do_jump     = accept && !ret && !call && jump;
    do_skip     = accept && !ret && !call && !jump && skip;
    stack_empty = (sp == '0);
    stack_full  = (sp == SP_W'(STACK_DEPTH));
    push_idx    = IDX_W'(sp);
    pop_idx     = IDX_W'(sp - SP_W'(1));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the pre-edge value of the registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      instr_addr      <= '0;
      pc              <= '0;
      instr_valid     <= 1'b0;
      sp              <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!pause) begin
      // Default: sequential fetch, wrapping silently at the top of memory.
      pc          <= instr_addr;
      instr_addr  <= instr_addr + PC_WIDTH'(1);
      instr_valid <= 1'b1;

      // Any redirect squashes the word already in flight from the ROM.
      if (do_ret) begin
        instr_valid <= 1'b0;
        if (stack_empty) begin
          stack_underflow <= 1'b1;
          instr_addr      <= '0;
        end else begin
          instr_addr <= stack[pop_idx];
          sp         <= sp - SP_W'(1);
        end
      end else if (do_call) begin
        instr_valid <= 1'b0;
        instr_addr  <= target;
        if (stack_full) stack_overflow <= 1'b1;
        else            sp <= sp + SP_W'(1);
      end else if (do_jump) begin
        instr_valid <= 1'b0;
        instr_addr  <= target;
      end else if (do_skip) begin
        // Fetch keeps going; only the next instruction (pc+1) is squashed.
        instr_valid <= 1'b0;
      end
    end
  end

  // NOTE: stack storage is deliberately not reset; an entry is only ever read
  // after it has been written, since the pointer is reset to empty.
  always_ff @(posedge clk) begin
    if (reset_n && do_call && !stack_full)
      stack[push_idx] <= pc + PC_WIDTH'(1);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit. A synchronous ROM with ROM[i] = i feeds
// the DUT; it holds its output while pause is high, as the core's program ROM
// is read-enabled by !pause. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_fetch_unit;

  localparam int PW = 12;
  localparam int IW = 16;
  localparam int SD = 8;

  logic          clk = 1'b0;
  logic          reset_n, pause, skip, jump, call, ret;
  logic [PW-1:0] target, instr_addr, pc;
  logic [IW-1:0] instr_data, instr;
  logic          instr_valid, stack_overflow, stack_underflow;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.PC_WIDTH(PW), .STACK_DEPTH(SD), .INSTR_WIDTH(IW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .pause           (pause),
    .skip            (skip),
    .jump            (jump),
    .call            (call),
    .ret             (ret),
    .target          (target),
    .instr_addr      (instr_addr),
    .instr_data      (instr_data),
    .instr           (instr),
    .pc              (pc),
    .instr_valid     (instr_valid),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!pause) instr_data <= {4'h0, instr_addr};

  // Observed {valid, pc, instr} and its expected value for a valid fetch of p.
  function automatic logic [28:0] obs();
    return {instr_valid, pc, instr};
  endfunction

  function automatic logic [28:0] fetched(input logic [PW-1:0] p);
    return {1'b1, p, 4'h0, p};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Redirect with a jump from a valid cycle; returns on the cycle with pc=t.
  task automatic go_to(input logic [PW-1:0] t);
    jump = 1'b1; target = t;
    step();
    jump = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pause = 1'b0; skip = 1'b0; jump = 1'b0; call = 1'b0;
    ret = 1'b0; target = '0;
    step(); step();
    checks++;
    if ({instr_addr, pc, instr_valid, stack_overflow, stack_underflow} !== 27'd0) begin
      errors++;
      $display("FAIL reset_state: got addr=%h pc=%h v=%b ovf=%b unf=%b exp all 0",
               instr_addr, pc, instr_valid, stack_overflow, stack_underflow);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (obs() !== fetched(PW'(i))) begin
        errors++;
        $display("FAIL seq_fetch %0d: got %h exp %h", i, obs(), fetched(PW'(i)));
      end
    end
  endtask

  // Enters with pc=5 valid.
  task automatic test_jump();
    jump = 1'b1; target = 12'h100;
    step();
    jump = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL jump_bubble: got valid=%b exp 0", instr_valid);
    end
    step();
    checks++;
    if (obs() !== fetched(12'h100)) begin
      errors++; $display("FAIL jump_land: got %h exp %h", obs(), fetched(12'h100));
    end
    step();
    checks++;
    if (obs() !== fetched(12'h101)) begin
      errors++; $display("FAIL jump_next: got %h exp %h", obs(), fetched(12'h101));
    end
  endtask

  task automatic test_call_ret();
    go_to(12'h010);
    call = 1'b1; target = 12'h200;
    step();
    call = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL call_bubble: got valid=%b exp 0", instr_valid);
    end
    step();
    checks++;
    if (obs() !== fetched(12'h200)) begin
      errors++; $display("FAIL call1_land: got %h exp %h", obs(), fetched(12'h200));
    end
    repeat (5) step();
    call = 1'b1; target = 12'h300;
    step();
    call = 1'b0;
    step();
    checks++;
    if (obs() !== fetched(12'h300)) begin
      errors++; $display("FAIL call2_land: got %h exp %h", obs(), fetched(12'h300));
    end
    ret = 1'b1;
    step();
    ret = 1'b0;
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++; $display("FAIL ret_bubble: got valid=%b exp 0", instr_valid);
    end
    step();
    checks++;
    if (obs() !== fetched(12'h206)) begin
      errors++; $display("FAIL ret1_land: got %h exp %h", obs(), fetched(12'h206));
    end
    ret = 1'b1;
    step();
    ret = 1'b0;
    step();
    checks++;
    if (obs() !== fetched(12'h011)) begin
      errors++; $display("FAIL ret2_land: got %h exp %h", obs(), fetched(12'h011));
    end
    checks++;
    if ({stack_overflow, stack_underflow} !== 2'b00) begin
      errors++;
      $display("FAIL call_ret_flags: got %b%b exp 00", stack_overflow, stack_underflow);
    end
  endtask

  task automatic test_skip();
    go_to(12'h007);
    skip = 1'b1;
    step();
    // skip stays high through the bubble cycle and must be ignored there.
    checks++;
    if ({instr_valid, pc} !== {1'b0, 12'h008}) begin
      errors++; $display("FAIL skip_squash: got v=%b pc=%h exp v=0 pc=008", instr_valid, pc);
    end
    step();
    skip = 1'b0;
    checks++;
    if (obs() !== fetched(12'h009)) begin
      errors++; $display("FAIL skip_resume: got %h exp %h", obs(), fetched(12'h009));
    end
    step();
    checks++;
    if (obs() !== fetched(12'h00A)) begin
      errors++; $display("FAIL skip_after: got %h exp %h", obs(), fetched(12'h00A));
    end
  endtask

  task automatic test_pause();
    go_to(12'h004);
    pause = 1'b1; jump = 1'b1; target = 12'h3AB;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({instr_addr, obs()} !== {12'h005, fetched(12'h004)}) begin
        errors++;
        $display("FAIL pause_hold %0d: got addr=%h %h exp addr=005 %h",
                 i, instr_addr, obs(), fetched(12'h004));
      end
    end
    pause = 1'b0; jump = 1'b0;
    step();
    checks++;
    if (obs() !== fetched(12'h005)) begin
      errors++; $display("FAIL pause_resume: got %h exp %h", obs(), fetched(12'h005));
    end
    step();
    checks++;
    if (obs() !== fetched(12'h006)) begin
      errors++; $display("FAIL pause_next: got %h exp %h", obs(), fetched(12'h006));
    end
  endtask

  task automatic test_wrap();
    go_to(12'hFFE);
    step();
    checks++;
    if (obs() !== fetched(12'hFFF)) begin
      errors++; $display("FAIL wrap_top: got %h exp %h", obs(), fetched(12'hFFF));
    end
    step();
    checks++;
    if ({instr_addr, obs(), stack_overflow, stack_underflow} !==
        {12'h001, fetched(12'h000), 2'b00}) begin
      errors++;
      $display("FAIL wrap_zero: got addr=%h %h flags=%b%b exp addr=001 %h flags=00",
               instr_addr, obs(), stack_overflow, stack_underflow, fetched(12'h000));
    end
  endtask

  // Calls k=0..8 target 0x500+16k; call 0 is made from pc 0x400.
  task automatic test_stack_limits();
    logic [PW-1:0] exp_pc;
    go_to(12'h400);
    for (int k = 0; k <= SD; k++) begin
      if (k == SD) begin
        checks++;
        if (stack_overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_early: got %b exp 0", stack_overflow);
        end
      end
      call = 1'b1; target = PW'(12'h500 + 16 * k);
      step();
      call = 1'b0;
      step();
    end
    checks++;
    if ({stack_overflow, obs()} !== {1'b1, fetched(12'h580)}) begin
      errors++;
      $display("FAIL ovf_call: got ovf=%b %h exp ovf=1 %h",
               stack_overflow, obs(), fetched(12'h580));
    end
    for (int j = 1; j <= SD + 1; j++) begin
      if (j <= SD - 1)  exp_pc = PW'(12'h500 + 16 * (SD - 1 - j) + 1);
      else if (j == SD) exp_pc = 12'h401;
      else              exp_pc = 12'h000;
      ret = 1'b1;
      step();
      ret = 1'b0;
      step();
      checks++;
      if (obs() !== fetched(exp_pc)) begin
        errors++; $display("FAIL ret_chain %0d: got %h exp %h", j, obs(), fetched(exp_pc));
      end
    end
    checks++;
    if ({stack_overflow, stack_underflow} !== 2'b11) begin
      errors++;
      $display("FAIL unf_flag: got %b%b exp 11", stack_overflow, stack_underflow);
    end
  endtask

  task automatic test_mid_reset();
    step(); step();
    reset_n = 1'b0;
    step();
    checks++;
    if ({instr_addr, pc, instr_valid, stack_overflow, stack_underflow} !== 27'd0) begin
      errors++;
      $display("FAIL mid_reset: got addr=%h pc=%h v=%b ovf=%b unf=%b exp all 0",
               instr_addr, pc, instr_valid, stack_overflow, stack_underflow);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (obs() !== fetched(12'h000)) begin
      errors++; $display("FAIL mid_reset_restart: got %h exp %h", obs(), fetched(12'h000));
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_call_ret();
    test_skip();
    test_pause();
    test_wrap();
    test_stack_limits();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
